rr_arbiter4: RTL and testbench



---
 rtl/rr_arbiter4_pkg.sv | 27 ++
 rtl/rr_arbiter4_pick4.sv | 34 +++
 rtl/rr_arbiter4.sv | 107 ++++++++++
 tb/tb_rr_arbiter4.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter4_pkg.sv
// ============================================================================
// rr_arbiter4_pkg : shared types and constants for the 4-way round-robin arbiter
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_arbiter4_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    // 2-to-4 decode of an owner index into its one-hot grant
    function automatic logic [NUM_REQ-1:0] dec_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter4_pick4.sv
// ============================================================================
// rr_pick4 : combinational round-robin picker, search starts just after ptr
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick4
    import rr_arbiter4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic [SEL_W-1:0]   winner_o,
    output logic               any_o
);

    logic [SEL_W-1:0] w_idx;

    // Walk from the farthest offset to the nearest so the nearest set bit wins
    always_comb begin
        winner_o = ptr_i;
        w_idx    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_idx = ptr_i + SEL_W'(i);
            if (req_i[w_idx]) begin
                winner_o = w_idx;
            end
        end
    end

    assign any_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter4.sv
// ============================================================================
// rr_arbiter4 : 4-requester round-robin arbiter with hold timeout
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req_i,
    input  logic [3:0]   done_i,
    output logic [1:0]   sel_o,
    output logic [3:0]   gnt_o,
    output logic         busy_o,
    output logic         timeout_o
);

    localparam logic [CNT_W-1:0] C_HOLD = HOLD_MAX[CNT_W-1:0];

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [NUM_REQ-1:0] gnt_q,   gnt_d;
    logic [SEL_W-1:0]   ptr_q,   ptr_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               timeout_q, timeout_d;

    logic [SEL_W-1:0]   w_winner;
    logic               w_any;
    logic               w_at_max;
    logic               w_release;

    rr_pick4 u_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .winner_o (w_winner),
        .any_o    (w_any)
    );

    assign w_at_max  = (cnt_q == C_HOLD);
    assign w_release = done_i[sel_q] | ~req_i[sel_q] | w_at_max;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (w_any) begin
                    state_d = ST_OWN;
                    sel_d   = w_winner;
                    gnt_d   = dec_onehot(w_winner);
                    ptr_d   = w_winner;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_OWN: begin
                if (w_release) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    // A coincident done or dropped request is a normal release
                    timeout_d = w_at_max & ~done_i[sel_q] & req_i[sel_q];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            gnt_q     <= '0;
            ptr_q     <= 2'b11;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign sel_o     = sel_q;
    assign gnt_o     = gnt_q;
    assign busy_o    = (state_q == ST_OWN);
    assign timeout_o = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
// ============================================================================
// tb_rr_arbiter4 : directed vector table plus randomized reference-model run
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter4;

    localparam int HOLD_MAX = 15;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_i;
    logic [3:0] done_i;
    logic [1:0] sel_o;
    logic [3:0] gnt_o;
    logic       busy_o;
    logic       timeout_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    rr_arbiter4 #(.HOLD_MAX(HOLD_MAX), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .done_i    (done_i),
        .sel_o     (sel_o),
        .gnt_o     (gnt_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es,
                         input logic eb, input logic et);
        tests++;
        if (gnt_o !== eg || sel_o !== es || busy_o !== eb || timeout_o !== et) begin
            fails++;
            $display("FAIL %s: got gnt=%b sel=%0d busy=%b timeout=%b, want gnt=%b sel=%0d busy=%b timeout=%b",
                     name, gnt_o, sel_o, busy_o, timeout_o, eg, es, eb, et);
        end
    endtask

    function automatic void add(input logic [3:0] rq, input logic [3:0] dn, input logic [3:0] g,
                                input logic [1:0] s, input logic b, input logic t);
        vec_t v;
        v.req = rq; v.done = dn; v.gnt = g; v.sel = s; v.busy = b; v.to = t;
        vecs.push_back(v);
    endfunction

    task automatic step(input logic [3:0] rq, input logic [3:0] dn);
        req_i  = rq;
        done_i = dn;
        @(posedge clk);
        #1;
    endtask

    // Reference model state: owner of -1 means nobody holds the resource
    int         m_owner, m_last, m_held;
    logic [1:0] m_sel;
    logic       m_to;

    task automatic model_reset();
        m_owner = -1; m_last = 3; m_held = 0; m_sel = 2'd0; m_to = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] rq, input logic [3:0] dn);
        bit by_done, by_drop, by_time;
        if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (m_owner < 0 && rq[c]) begin
                    m_owner = c; m_last = c; m_held = 1; m_sel = 2'(c);
                end
            end
        end else begin
            by_done = dn[m_owner];
            by_drop = !rq[m_owner];
            by_time = (m_held == HOLD_MAX);
            if (by_done || by_drop || by_time) begin
                m_to    = by_time && !by_done && !by_drop;
                m_owner = -1;
            end else begin
                m_held++;
                m_to = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        req_i  = 4'b1111;
        done_i = 4'b0000;

        // Reset with all requests pending
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;

        // Rotation with done in each grant's second cycle
        add(4'hF, 4'h0, 4'b0001, 2'd0, 1, 0);
        add(4'hF, 4'h0, 4'b0001, 2'd0, 1, 0);
        add(4'hF, 4'h1, 4'b0000, 2'd0, 0, 0);
        add(4'hF, 4'h0, 4'b0010, 2'd1, 1, 0);
        add(4'hF, 4'h0, 4'b0010, 2'd1, 1, 0);
        add(4'hF, 4'h2, 4'b0000, 2'd1, 0, 0);
        add(4'hF, 4'h0, 4'b0100, 2'd2, 1, 0);
        add(4'hF, 4'h0, 4'b0100, 2'd2, 1, 0);
        add(4'hF, 4'h4, 4'b0000, 2'd2, 0, 0);
        add(4'hF, 4'h0, 4'b1000, 2'd3, 1, 0);
        add(4'hF, 4'h0, 4'b1000, 2'd3, 1, 0);
        add(4'hF, 4'h8, 4'b0000, 2'd3, 0, 0);
        add(4'hF, 4'h0, 4'b0001, 2'd0, 1, 0);
        add(4'h0, 4'h0, 4'b0000, 2'd0, 0, 0);
        add(4'h0, 4'h0, 4'b0000, 2'd0, 0, 0);
        // Two requesters alternate
        add(4'h5, 4'h0, 4'b0100, 2'd2, 1, 0);
        add(4'h5, 4'h0, 4'b0100, 2'd2, 1, 0);
        add(4'h5, 4'h0, 4'b0100, 2'd2, 1, 0);
        add(4'h5, 4'h4, 4'b0000, 2'd2, 0, 0);
        add(4'h5, 4'h0, 4'b0001, 2'd0, 1, 0);
        add(4'h5, 4'h0, 4'b0001, 2'd0, 1, 0);
        add(4'h5, 4'h0, 4'b0001, 2'd0, 1, 0);
        add(4'h5, 4'h1, 4'b0000, 2'd0, 0, 0);
        add(4'h5, 4'h0, 4'b0100, 2'd2, 1, 0);
        add(4'h5, 4'h4, 4'b0000, 2'd2, 0, 0);
        // Hold timeout: exactly HOLD_MAX granted cycles, then one timeout cycle
        for (int i = 0; i < HOLD_MAX; i++) add(4'h3, 4'h0, 4'b0001, 2'd0, 1, 0);
        add(4'h3, 4'h0, 4'b0000, 2'd0, 0, 1);
        add(4'h3, 4'h0, 4'b0010, 2'd1, 1, 0);
        add(4'h3, 4'h0, 4'b0010, 2'd1, 1, 0);
        // Foreign done pulses are ignored; dropping req releases without timeout
        add(4'h4, 4'h0, 4'b0000, 2'd1, 0, 0);
        add(4'h4, 4'h0, 4'b0100, 2'd2, 1, 0);
        add(4'h4, 4'h9, 4'b0100, 2'd2, 1, 0);
        add(4'h4, 4'h9, 4'b0100, 2'd2, 1, 0);
        add(4'h0, 4'h0, 4'b0000, 2'd2, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].req, vecs[i].done);
            check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].to);
        end

        // Asynchronous reset in the middle of a grant (count at 7)
        step(4'hF, 4'h0);
        check("midown_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        repeat (6) step(4'hF, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_now", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("async_reset_held", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(4'h4, 4'h0);
        check("after_reset_req2", 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'h0, 4'h0);
        check("after_reset_drop", 4'b0000, 2'd2, 1'b0, 1'b0);

        // Randomized run against the reference model
        rst_n = 1'b0;
        req_i = 4'h0;
        done_i = 4'h0;
        #7;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        for (int n = 0; n < 800; n++) begin
            logic [3:0] rq, dn;
            rq = req_i;
            if ($urandom_range(0, 9) == 0) rq = 4'($urandom_range(0, 15));
            dn = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            step(rq, dn);
            model_edge(rq, dn);
            check($sformatf("rand%0d", n), (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000,
                  m_sel, (m_owner >= 0), m_to);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
